// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Brief    : Instruction-memory, redirect and decode-side bundle of fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);
   logic [ADDRESS_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0]    imem_dout;
   logic                     halt;
   logic                     redirect_valid;
   logic [ADDRESS_WIDTH-1:0] redirect_pc;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_WIDTH-1:0]    out_instr;
   logic [ADDRESS_WIDTH-1:0] out_pc;
   logic [31:0]              perf_bubbles;

   modport master (
      output imem_addr,
      input  imem_dout,
      input  halt,
      input  redirect_valid,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output perf_bubbles
   );

   modport slave (
      input  imem_addr,
      output imem_dout,
      output halt,
      output redirect_valid,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  perf_bubbles
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Sequential instruction fetch into a DEPTH-entry prefetch FIFO with
//            redirect flush and halt; FETCH_PERF_EN adds a bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int                       ADDRESS_WIDTH = 32,
   parameter int                       DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = 32'hBFC0_0000,
   parameter int                       DEPTH         = 4
) (
   input wire           clk,
   input wire           rst_n,
   fetch_unit_if.master bus
);
   localparam int                       c_ptr_w      = $clog2(DEPTH);
   localparam int                       c_cnt_w      = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0]       c_depth      = c_cnt_w'(DEPTH);
   localparam logic [c_ptr_w-1:0]       c_ptr_one    = c_ptr_w'(1);
   localparam logic [c_cnt_w-1:0]       c_cnt_one    = c_cnt_w'(1);
   localparam logic [ADDRESS_WIDTH-1:0] c_pc_step    = ADDRESS_WIDTH'(4);
   localparam logic [ADDRESS_WIDTH-1:0] c_align_mask = ~ADDRESS_WIDTH'(3);

   logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
   logic [c_ptr_w-1:0]       head_q, head_d;
   logic [c_ptr_w-1:0]       tail_q, tail_d;
   logic [c_cnt_w-1:0]       count_q, count_d;
   logic [ADDRESS_WIDTH-1:0] ent_pc_q    [DEPTH];
   logic [ADDRESS_WIDTH-1:0] ent_pc_d    [DEPTH];
   logic [DATA_WIDTH-1:0]    ent_instr_q [DEPTH];
   logic [DATA_WIDTH-1:0]    ent_instr_d [DEPTH];

   logic w_out_valid;
   logic w_pop;
   logic w_push;

   assign w_out_valid = (count_q != '0);
   assign w_pop       = w_out_valid && bus.out_ready;
   // A pop frees the head slot in the same edge, so a full buffer can still accept.
   assign w_push      = !bus.redirect_valid && !bus.halt && ((count_q < c_depth) || w_pop);

   always_comb begin
      pc_d        = pc_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      ent_pc_d    = ent_pc_q;
      ent_instr_d = ent_instr_q;
      if (bus.redirect_valid) begin
         pc_d    = bus.redirect_pc & c_align_mask;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (w_push) begin
            ent_pc_d[tail_q]    = pc_q;
            ent_instr_d[tail_q] = bus.imem_dout;
            tail_d              = tail_q + c_ptr_one;
            pc_d                = pc_q + c_pc_step;
         end
         if (w_pop) begin
            head_d = head_q + c_ptr_one;
         end
         if (w_push && !w_pop) begin
            count_d = count_q + c_cnt_one;
         end else if (w_pop && !w_push) begin
            count_d = count_q - c_cnt_one;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         pc_q    <= pc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage needs no reset: it is only observed through a valid count.
   always_ff @(posedge clk) begin
      ent_pc_q    <= ent_pc_d;
      ent_instr_q <= ent_instr_d;
   end

   assign bus.imem_addr = pc_q;
   assign bus.out_valid = w_out_valid;
   assign bus.out_pc    = ent_pc_q[head_q];
   assign bus.out_instr = ent_instr_q[head_q];

`ifdef FETCH_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (!w_out_valid && bus.out_ready && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign bus.perf_bubbles = perf_q;
`else
   assign bus.perf_bubbles = 32'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed bench for fetch_unit with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
   localparam int          AW     = 32;
   localparam int          DW     = 32;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   chk_en = 1'b0;

   ent_t        mq[$];
   logic [31:0] m_pc   = RST_PC;
   logic [31:0] m_perf = 32'd0;

   fetch_unit_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   fetch_unit #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH   (DW),
      .RESET_PC     (RST_PC),
      .DEPTH        (DEPTH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Memory returns the inverted address so pc and instruction fields differ.
   assign bus.imem_dout = ~bus.imem_addr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin : model
      bit had;
      had = (mq.size() > 0);
      if (!rst_n) begin
         mq.delete();
         m_pc   = RST_PC;
         m_perf = 32'd0;
      end else begin
`ifdef FETCH_PERF_EN
         if (!had && bus.out_ready && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
`endif
         if (bus.redirect_valid) begin
            mq.delete();
            m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
         end else begin
            if (had && bus.out_ready) void'(mq.pop_front());
            if (!bus.halt && mq.size() < DEPTH) begin
               mq.push_back('{pc: m_pc, instr: ~m_pc});
               m_pc = m_pc + 32'd4;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_valid", {31'd0, bus.out_valid}, {31'd0, (mq.size() > 0)});
         chk("m_addr", bus.imem_addr, m_pc);
         chk("m_perf", bus.perf_bubbles, m_perf);
         if (mq.size() > 0) begin
            chk("m_pc", bus.out_pc, mq[0].pc);
            chk("m_instr", bus.out_instr, mq[0].instr);
         end
      end
   end

   initial begin
      bus.halt           = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      bus.out_ready      = 1'b0;
      rst_n              = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_addr", bus.imem_addr, 32'hBFC0_0000);
      chk("rst_perf", bus.perf_bubbles, 32'd0);

      // Reset release with decode always ready.
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("first_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("first_pc", bus.out_pc, 32'hBFC0_0000);
      chk("first_instr", bus.out_instr, 32'h403F_FFFF);
`ifdef FETCH_PERF_EN
      chk("first_perf", bus.perf_bubbles, 32'd1);
`else
      chk("first_perf", bus.perf_bubbles, 32'd0);
`endif
      @(negedge clk);
      chk("stream_pc1", bus.out_pc, 32'hBFC0_0004);
      @(negedge clk);
      chk("stream_pc2", bus.out_pc, 32'hBFC0_0008);

      // Back-pressure fills the buffer, then drain without a gap.
      rst_n = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("full_addr", bus.imem_addr, 32'hBFC0_0010);
      chk("full_head", bus.out_pc, 32'hBFC0_0000);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("drain_pc", bus.out_pc, 32'hBFC0_0000 + 32'(4 * i));
         @(negedge clk);
      end

      // Leave three entries, then redirect to an unaligned target.
      bus.halt = 1'b1;
      @(negedge clk);
      bus.halt = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_1003;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      chk("redir_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("redir_addr", bus.imem_addr, 32'h0000_1000);
      @(negedge clk);
      chk("redir_pc", bus.out_pc, 32'h0000_1000);

      // Halt: drains, fetch address frozen, resumes without skip.
      repeat (3) @(negedge clk);
      bus.halt = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("halt_addr", bus.imem_addr, 32'h0000_1010);
      end
      chk("halt_empty", {31'd0, bus.out_valid}, 32'd0);
      bus.halt = 1'b0;
      @(negedge clk);
      chk("resume_pc0", bus.out_pc, 32'h0000_1010);
      @(negedge clk);
      chk("resume_pc1", bus.out_pc, 32'h0000_1014);

      // Redirect together with pop and halt.
      bus.halt           = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_2000;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      chk("combo_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("combo_addr", bus.imem_addr, 32'h0000_2000);
      @(negedge clk);
      chk("combo_hold", bus.imem_addr, 32'h0000_2000);
      bus.halt = 1'b0;
      @(negedge clk);
      chk("combo_pc", bus.out_pc, 32'h0000_2000);
      repeat (2) @(negedge clk);

      // Reset mid-stream beats redirect and halt.
      rst_n              = 1'b0;
      bus.halt           = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_3000;
      @(negedge clk);
      rst_n              = 1'b1;
      bus.halt           = 1'b0;
      bus.redirect_valid = 1'b0;
      chk("rst2_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst2_addr", bus.imem_addr, 32'hBFC0_0000);
      repeat (3) @(negedge clk);

      // Fetch address wraps past all-ones.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFF9;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFF8);
      @(negedge clk);
      chk("wrap_pc0", bus.out_pc, 32'hFFFF_FFF8);
      @(negedge clk);
      chk("wrap_pc1", bus.out_pc, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("wrap_pc2", bus.out_pc, 32'h0000_0000);
      chk("wrap_addr3", bus.imem_addr, 32'h0000_0004);
      repeat (2) @(negedge clk);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDRESS_WIDTH, 32, width of program counter and memory address.
REQ-002 Parameter DATA_WIDTH, 32, instruction width.
REQ-003 Parameter RESET_PC, 32'hBFC00000, first fetch address after reset.
REQ-004 Parameter DEPTH, 4, prefetch buffer entries; power of two, at least 2.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 imem_addr  output  ADDRESS_WIDTH  byte address to instruction memory.
REQ-008 imem_dout  input  DATA_WIDTH  instruction word, combinational read of imem_addr in the same cycle.
REQ-009 halt  input  1  stops new fetches; buffered entries still drain.
REQ-010 redirect_valid  input  1  branch/jump redirect request.
REQ-011 redirect_pc  input  ADDRESS_WIDTH  redirect target.
REQ-012 out_valid  output  1  buffer head holds a valid instruction.
REQ-013 out_ready  input  1  decode accepts head this cycle.
REQ-014 out_instr  output  DATA_WIDTH  head instruction.
REQ-015 out_pc  output  ADDRESS_WIDTH  byte address of head instruction.
REQ-016 perf_bubbles  output  32  count of decode-starved cycles (see Configuration).

Function
REQ-017 imem_addr SHALL equal the fetch PC register at all times.
REQ-018 Push condition: rst_n=1, redirect_valid=0, halt=0, and (count<DEPTH or pop this cycle); on push store {fetch PC, imem_dout} at tail and fetch PC += 4.
REQ-019 Pop condition: out_valid=1 and out_ready=1; head advances one entry.
REQ-020 out_valid SHALL be 1 exactly when count>0; out_instr/out_pc come from the head entry; no bypass, so a word pushed in cycle N is visible at earliest in cycle N+1.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including when full and when count=1.
REQ-022 Full (count=DEPTH) without pop: no push, fetch PC holds.
REQ-023 Head/tail pointers SHALL wrap modulo DEPTH; count is log2(DEPTH)+1 bits and never exceeds DEPTH.
REQ-024 Redirect: in a cycle with redirect_valid=1, no push occurs, and the buffer is flushed (count=0, pointers reset) at the edge; fetch PC <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}.
REQ-025 Redirect priority: redirect overrides push, pop and halt in the same cycle; a pop coinciding with redirect is still consumed by decode but the entry is discarded with the flush.
REQ-026 After redirect in cycle N, the target instruction SHALL be pushed in N+1 (if halt=0) and present with out_valid=1 in N+2.
REQ-027 halt=1 SHALL freeze the fetch PC and suppress pushes; pops continue; halt deassertion resumes from the held PC with no skipped or duplicated address.
REQ-028 Fetch PC arithmetic is modulo 2^ADDRESS_WIDTH; increment past all-ones wraps to zero.

Reset
REQ-029 While rst_n=0 at an edge: fetch PC <= RESET_PC, count/head/tail <= 0, perf_bubbles <= 0; no push.
REQ-030 Outputs after reset edge: out_valid=0, imem_addr=RESET_PC; out_instr/out_pc contents are don't-care while out_valid=0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries and override redirect and halt.
REQ-032 First push occurs in the first cycle with rst_n=1; out_valid rises one cycle later.

Configuration
REQ-033 Macro FETCH_PERF_EN: when defined, perf_bubbles increments by 1 every cycle with out_valid=0 and out_ready=1 (rst_n=1), saturating at 32'hFFFFFFFF.
REQ-034 Without FETCH_PERF_EN, no counter logic is built and perf_bubbles is tied to 0; all other behaviour is identical.

Verification
REQ-035 Reset release, out_ready=1, memory returns word=address -> out_valid rises cycle 2; out_pc sequence BFC00000, BFC00004, BFC00008 one per cycle.
REQ-036 out_ready=0 for 10 cycles -> count saturates at 4, imem_addr holds BFC00010; then out_ready=1 -> pcs BFC00000..BFC0000C drain, then BFC00010 follows without gap.
REQ-037 Redirect to 32'h00001003 while buffer holds 3 entries -> next cycle out_valid=0, imem_addr=00001000; cycle after, out_pc=00001000.
REQ-038 halt=1 for 5 cycles with out_ready=1 -> buffer drains to empty, imem_addr constant; halt=0 -> fetch resumes at held PC, no address repeated or skipped.
REQ-039 Redirect, pop and halt all asserted in the same cycle, and separately rst_n=0 mid-stream -> redirect/reset wins respectively; out_valid=0 next cycle, fetch PC = target or RESET_PC.
REQ-040 With FETCH_PERF_EN, out_ready=1 from reset release -> perf_bubbles=1 after first active cycle, unchanged while streaming, +1 per cycle in each redirect bubble; without macro stays 0.
